bg_scroll_layers: RTL and testbench
===================================

# bg_scroll_layers

Parametrised parallax background generator for the 1024x768 scrolling-background display path. It combines a tiled brick ground that scrolls at a selectable speed and NUM_CLOUDS independently parallaxed cloud channels. A frame-driven day/dusk/night/dawn sky state machine sets the sky palette and the sun/moon colour. It sits between the video timing generator and the output mux, and delivers registered 2-bit-per-channel RGB with fixed pipeline latency.

## Interface
- H_RES, 1024: active width; must be a multiple of 32.
- V_RES, 768: active height.
- GROUND_Y, 704: first ground row; must be < V_RES.
- NUM_CLOUDS, 4: cloud channels, 1..8.
- CLOUD_Y0, 160: row of cloud 0.
- CLOUD_DY, 48: vertical spacing between cloud channels.
- DWELL_FRAMES, 600: frames spent in DAY and in NIGHT.
- TRANS_FRAMES, 60: frames spent in DUSK and in DAWN.
- clk  in  1  pixel clock; sole clock.
- rst  in  1  reset, synchronous, active-high.
- bg_en  in  1  enable; 0 freezes all state and blanks the output.
- video_active  in  1  current pixel is visible.
- pix_x  in  11  horizontal pixel coordinate.
- pix_y  in  11  vertical pixel coordinate.
- vsync  in  1  vertical sync, synchronous to clk, active-high.
- scroll_en  in  1  allow positions to advance.
- scroll_dir  in  1  0 = scene moves left; 1 = scene moves right.
- speed  in  2  ground step per frame = 1 << speed (1, 2, 4 or 8 px).
- cycle_en  in  1  allow the sky FSM to advance.
- R, G, B  out  2 each  colour.
- pix_valid  out  1  video_active delayed to match the colour outputs.

## Operation
- frame_tick = vsync & ~vsync_q. vsync_q is a register, reset to 0. All state updates happen only on frame_tick with bg_en = 1.
- Ground position gnd_pos (11 b, range [0, H_RES), reset 0):
  - scroll_dir = 0: gnd_pos += step; if the result is >= H_RES, subtract H_RES.
  - scroll_dir = 1: gnd_pos -= step; on underflow, add H_RES.
  - No update when scroll_en = 0.
- frame_cnt (8 b, reset 0) increments on every frame_tick when bg_en = 1, independent of scroll_en.
- Cloud channel i:
  - Position cpos_i updates with the same rule but step = 1 only, on frame_ticks where frame_cnt[i:0] == 0. Channel i therefore moves 1 px every 2^(i+1) frames.
  - Screen x = (i·H_RES/NUM_CLOUDS + 64 − cpos_i) mod H_RES; y = CLOUD_Y0 + i·CLOUD_DY.
  - Sprite: 20x8 pixels, scale 4 (80x32 on screen). A cloud is clipped at the right edge, not wrapped.
- Ground:
  - 8x8 brick sprite at scale 4 (32 px tiles).
  - Tile column = ((pix_x + gnd_pos) mod H_RES)[4:2]; tile row = (pix_y − GROUND_Y)[4:2].
  - Brick bit 1 → 11/01/00; bit 0 → black.
- Sun/moon: circle, centre (H_RES−160, 128), radius 48; inside when dx² + dy² <= 2304.
- Sky FSM (reset DAY, dwell counter 0): DAY → DUSK → NIGHT → DAWN → DAY.
  - Each state lasts its frame count (DWELL_FRAMES or TRANS_FRAMES). The counter clears on every transition.
  - cycle_en = 0 holds both the state and the counter.
- Colours (R/G/B), per state:
  - Sky: DAY 10/10/11; DUSK 11/01/01; NIGHT 00/00/01; DAWN 10/01/10.
  - Sun (DAY, DUSK, DAWN): 11/11/00. Moon (NIGHT): 10/10/10.
  - Clouds: 11/11/11, except NIGHT 01/01/01.
- Priority, highest first: !video_active or !bg_en → 00/00/00; ground; cloud; sun/moon; sky.

## Timing
- Latency is 2 clk from pix_x/pix_y/video_active to R/G/B/pix_valid.
  - Stage 1 registers the coordinates, video_active and all region hits, including the distance compare.
  - Stage 2 registers the colour.
- Positions and sky state change only in the cycle after frame_tick, so every pixel of a frame sees stable state.
- Inputs sampled on the frame_tick cycle:
  - scroll_en, scroll_dir, speed and cycle_en.
  - A change takes effect at the next tick.
- Reset:
  - rst clears positions, counters, FSM, vsync_q and both pipeline stages.
  - R/G/B = 0 and pix_valid = 0 from the first clk after rst is sampled high, including mid-frame.
  - After release, the first valid output appears 2 clk later.
- A vsync held high across many cycles produces exactly one tick.
- bg_en = 0 while a tick occurs: the tick is discarded, not deferred.

## Structure
- Shared package bg_scroll_pkg holds:
  - the sky-state enum;
  - the palette constants;
  - the brick and cloud sprite row functions;
  - the sun centre and radius constants.
- Sub-module bg_scroll_pos: one modulo-H_RES up/down position register with a step input and an enable. It is instantiated once for the ground and once per cloud channel.

## Test plan
- Reset:
  - Stimulus: rst high 1 clk mid-line.
  - Required: outputs 0 at the next edge; gnd_pos = 0; state DAY; first nonzero pixel 2 clk after release with video_active = 1.
- Ground wrap:
  - Stimulus: speed = 3, scroll_dir = 0, gnd_pos = 1020, one tick.
  - Required: gnd_pos = 4. With scroll_dir = 1 from 4, one tick gives 1020.
- Parallax:
  - Stimulus: 8 ticks with scroll_en = 1, speed = 0.
  - Required: ground moved 8 px; cloud0 4 px; cloud1 2 px; cloud2 1 px.
- Sky FSM:
  - Stimulus: DWELL_FRAMES = 2, TRANS_FRAMES = 1; count ticks.
  - Required: DAY→DUSK after 2, NIGHT after 3, DAWN after 5, DAY after 6. The pixel at (864, 128) reads 10/10/10 only in NIGHT.
  - With cycle_en = 0 the state holds.
- Priority and latency:
  - Stimulus: pixel (0, 704) with gnd_pos = 0.
  - Required: output 11/01/00 exactly 2 clk later.
  - Pixel (0, 703) in DAY outside any cloud → 10/10/11.
- Stretched vsync / bg_en:
  - Stimulus: vsync high 100 clk.
  - Required: exactly one position update.
  - With bg_en = 0 during a tick: no update, output 0.

Source files
------------

// File: rtl/bg_scroll_pkg.sv
// Shared sky-state type, palette, sun geometry and sprite rows
// for the parallax background generator.
package bg_scroll_pkg;

    localparam int POS_W = 11;

    typedef enum logic [1:0] {
        DAY   = 2'd0,
        DUSK  = 2'd1,
        NIGHT = 2'd2,
        DAWN  = 2'd3
    } sky_e;

    // Packed as {R[1:0], G[1:0], B[1:0]}
    typedef logic [5:0] rgb_t;

    localparam rgb_t C_BLACK   = 6'b00_00_00;
    localparam rgb_t C_DAY     = 6'b10_10_11;
    localparam rgb_t C_DUSK    = 6'b11_01_01;
    localparam rgb_t C_NIGHT   = 6'b00_00_01;
    localparam rgb_t C_DAWN    = 6'b10_01_10;
    localparam rgb_t C_SUN     = 6'b11_11_00;
    localparam rgb_t C_MOON    = 6'b10_10_10;
    localparam rgb_t C_CLOUD   = 6'b11_11_11;
    localparam rgb_t C_CLOUD_N = 6'b01_01_01;
    localparam rgb_t C_BRICK   = 6'b11_01_00;

    localparam int SUN_DX  = 160;
    localparam int SUN_CY  = 128;
    localparam int SUN_RAD = 48;
    localparam int SUN_R2  = SUN_RAD * SUN_RAD;

    localparam int CLOUD_W     = 80;
    localparam int CLOUD_H     = 32;
    localparam int CLOUD_X_OFF = 64;

    function automatic sky_e next_sky(input sky_e s);
        sky_e n;
        unique case (s)
            DAY:     n = DUSK;
            DUSK:    n = NIGHT;
            NIGHT:   n = DAWN;
            default: n = DAY;
        endcase
        return n;
    endfunction

    function automatic rgb_t sky_rgb(input sky_e s);
        rgb_t c;
        unique case (s)
            DAY:     c = C_DAY;
            DUSK:    c = C_DUSK;
            NIGHT:   c = C_NIGHT;
            default: c = C_DAWN;
        endcase
        return c;
    endfunction

    // Column c of a row is bit [7-c]; rows 3 and 7 are mortar.
    function automatic logic [7:0] brick_row(input logic [2:0] r);
        logic [7:0] v;
        unique case (r)
            3'd0, 3'd1, 3'd2: v = 8'b1111_1110;
            3'd4, 3'd5, 3'd6: v = 8'b1110_1111;
            default:          v = 8'b0000_0000;
        endcase
        return v;
    endfunction

    // Column c of a row is bit [19-c].
    function automatic logic [19:0] cloud_row(input logic [2:0] r);
        logic [19:0] v;
        unique case (r)
            3'd0:    v = 20'b0000_0011_1100_0000_0000;
            3'd1:    v = 20'b0000_1111_1111_0000_0000;
            3'd2:    v = 20'b0011_1111_1111_1100_0000;
            3'd3:    v = 20'b0111_1111_1111_1111_0000;
            3'd4:    v = 20'b1111_1111_1111_1111_1110;
            3'd5:    v = 20'b1111_1111_1111_1111_1111;
            3'd6:    v = 20'b0111_1111_1111_1111_1110;
            default: v = 20'b0001_1111_1111_1111_1000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/bg_scroll_pos.sv
// Modulo-H_RES scroll position register with up/down step.
// Used for the ground and for each cloud channel.
module bg_scroll_pos
    import bg_scroll_pkg::*;
#(
    parameter int H_RES = 1024
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             dir_i,
    input  logic [3:0]       step_i,
    output logic [POS_W-1:0] pos_o
);

    localparam logic [POS_W:0] HRES = (POS_W + 1)'(H_RES);

    logic [POS_W-1:0] pos_q;
    logic [POS_W-1:0] pos_d;
    logic [POS_W:0]   up;
    logic [POS_W:0]   dn;

    always_comb begin
        up    = {1'b0, pos_q} + (POS_W + 1)'(step_i);
        dn    = {1'b0, pos_q} - (POS_W + 1)'(step_i);
        pos_d = pos_q;
        if (en_i) begin
            if (!dir_i) begin
                pos_d = (up >= HRES) ? POS_W'(up - HRES) : up[POS_W-1:0];
            end else begin
                // Borrow into the top bit marks an underflow
                pos_d = dn[POS_W] ? POS_W'(dn + HRES) : dn[POS_W-1:0];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pos_q <= '0;
        end else begin
            pos_q <= pos_d;
        end
    end

    assign pos_o = pos_q;

endmodule

// File: rtl/bg_scroll_layers.sv
// Parallax background: scrolling brick ground, cloud channels and a
// frame-driven sky cycle, two-stage registered colour pipeline.
module bg_scroll_layers
    import bg_scroll_pkg::*;
#(
    parameter int H_RES        = 1024,
    parameter int V_RES        = 768,
    parameter int GROUND_Y     = 704,
    parameter int NUM_CLOUDS   = 4,
    parameter int CLOUD_Y0     = 160,
    parameter int CLOUD_DY     = 48,
    parameter int DWELL_FRAMES = 600,
    parameter int TRANS_FRAMES = 60
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        bg_en_i,
    input  logic        video_active_i,
    input  logic [10:0] pix_x_i,
    input  logic [10:0] pix_y_i,
    input  logic        vsync_i,
    input  logic        scroll_en_i,
    input  logic        scroll_dir_i,
    input  logic [1:0]  speed_i,
    input  logic        cycle_en_i,
    output logic [1:0]  r_o,
    output logic [1:0]  g_o,
    output logic [1:0]  b_o,
    output logic        pix_valid_o
);

    localparam logic [11:0] HRES   = 12'(H_RES);
    localparam logic [10:0] GY     = 11'(GROUND_Y);
    localparam logic [10:0] VR     = 11'(V_RES);
    localparam logic [15:0] DW_END = 16'(DWELL_FRAMES - 1);
    localparam logic [15:0] TR_END = 16'(TRANS_FRAMES - 1);
    localparam logic signed [11:0] SCX = 12'(H_RES - SUN_DX);
    localparam logic signed [11:0] SCY = 12'(SUN_CY);

    logic       vsync_q;
    logic       tick;
    logic [7:0] frame_cnt_q;
    sky_e       state_q;
    logic [15:0] dwell_q;

    logic [POS_W-1:0] gnd_pos;
    logic [POS_W-1:0] cpos [NUM_CLOUDS];

    assign tick = vsync_i & ~vsync_q & bg_en_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vsync_q     <= 1'b0;
            frame_cnt_q <= '0;
            state_q     <= DAY;
            dwell_q     <= '0;
        end else begin
            vsync_q <= vsync_i;
            if (tick) begin
                frame_cnt_q <= frame_cnt_q + 8'd1;
                if (cycle_en_i) begin
                    if (dwell_q == ((state_q == DAY || state_q == NIGHT)
                                    ? DW_END : TR_END)) begin
                        state_q <= next_sky(state_q);
                        dwell_q <= '0;
                    end else begin
                        dwell_q <= dwell_q + 16'd1;
                    end
                end
            end
        end
    end

    bg_scroll_pos #(.H_RES(H_RES)) u_gnd (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (tick & scroll_en_i),
        .dir_i  (scroll_dir_i),
        .step_i (4'd1 << speed_i),
        .pos_o  (gnd_pos)
    );

    logic [NUM_CLOUDS-1:0] cl_hit;

    for (genvar i = 0; i < NUM_CLOUDS; i++) begin : g_cloud
        localparam logic [7:0]  MASK  = 8'((1 << (i + 1)) - 1);
        localparam logic [11:0] CBASE =
            12'((i * H_RES / NUM_CLOUDS + CLOUD_X_OFF) % H_RES);
        localparam logic [10:0] CY    = 11'(CLOUD_Y0 + i * CLOUD_DY);

        logic [11:0] sx_t;
        logic [10:0] sx;
        logic [10:0] dx;
        logic [10:0] dy;
        logic        in_box;
        logic [19:0] row;
        logic [4:0]  idx;
        logic        hit;

        bg_scroll_pos #(.H_RES(H_RES)) u_pos (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .en_i   (tick & scroll_en_i & ((frame_cnt_q & MASK) == 8'd0)),
            .dir_i  (scroll_dir_i),
            .step_i (4'd1),
            .pos_o  (cpos[i])
        );

        // No wrap on the right: pixels left of sx never belong to it
        always_comb begin
            sx_t   = CBASE + HRES - {1'b0, cpos[i]};
            sx     = (sx_t >= HRES) ? 11'(sx_t - HRES) : sx_t[10:0];
            dx     = pix_x_i - sx;
            dy     = pix_y_i - CY;
            in_box = (pix_x_i >= sx) && (dx < 11'(CLOUD_W))
                  && (pix_y_i >= CY) && (dy < 11'(CLOUD_H));
            row    = cloud_row(dy[4:2]);
            idx    = in_box ? (5'd19 - dx[6:2]) : 5'd0;
            hit    = in_box & row[idx];
        end

        assign cl_hit[i] = hit;
    end

    logic [11:0] gx;
    logic [10:0] gy;
    logic        gnd_in;
    logic [7:0]  brow;
    logic        gbit;
    logic signed [11:0] sdx;
    logic signed [11:0] sdy;
    logic signed [23:0] sx2;
    logic signed [23:0] sy2;
    logic [24:0] d2;
    logic        sun_in;
    logic        unused_bits;

    always_comb begin
        gx     = {1'b0, pix_x_i} + {1'b0, gnd_pos};
        gx     = (gx >= HRES) ? (gx - HRES) : gx;
        gy     = pix_y_i - GY;
        gnd_in = (pix_y_i >= GY) && (pix_y_i < VR);
        brow   = brick_row(gy[4:2]);
        gbit   = brow[3'd7 - gx[4:2]];
        sdx    = $signed({1'b0, pix_x_i}) - SCX;
        sdy    = $signed({1'b0, pix_y_i}) - SCY;
        sx2    = sdx * sdx;
        sy2    = sdy * sdy;
        d2     = {1'b0, sx2} + {1'b0, sy2};
        sun_in = d2 <= 25'(SUN_R2);
    end

    assign unused_bits = ^{gx[11:5], gx[1:0], gy[10:5], gy[1:0]};

    logic act_q;
    logic vis_q;
    logic gnd_q;
    logic gbit_q;
    logic cloud_q;
    logic sun_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            act_q   <= 1'b0;
            vis_q   <= 1'b0;
            gnd_q   <= 1'b0;
            gbit_q  <= 1'b0;
            cloud_q <= 1'b0;
            sun_q   <= 1'b0;
        end else begin
            act_q   <= video_active_i;
            vis_q   <= video_active_i & bg_en_i;
            gnd_q   <= gnd_in;
            gbit_q  <= gbit;
            cloud_q <= |cl_hit;
            sun_q   <= sun_in;
        end
    end

    rgb_t rgb_d;
    rgb_t rgb_q;
    logic valid_q;

    always_comb begin
        rgb_d = C_BLACK;
        if (!vis_q) begin
            rgb_d = C_BLACK;
        end else if (gnd_q) begin
            rgb_d = gbit_q ? C_BRICK : C_BLACK;
        end else if (cloud_q) begin
            rgb_d = (state_q == NIGHT) ? C_CLOUD_N : C_CLOUD;
        end else if (sun_q) begin
            rgb_d = (state_q == NIGHT) ? C_MOON : C_SUN;
        end else begin
            rgb_d = sky_rgb(state_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rgb_q   <= C_BLACK;
            valid_q <= 1'b0;
        end else begin
            rgb_q   <= rgb_d;
            valid_q <= act_q;
        end
    end

    assign r_o         = rgb_q[5:4];
    assign g_o         = rgb_q[3:2];
    assign b_o         = rgb_q[1:0];
    assign pix_valid_o = valid_q;

endmodule

// File: tb/tb_bg_scroll_layers.sv
// Directed bench for bg_scroll_layers: reset, latency, priority,
// ground wrap, parallax, vsync edge handling and the sky cycle.
module tb_bg_scroll_layers;
    import bg_scroll_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        bg_en;
    logic        video_active;
    logic [10:0] px;
    logic [10:0] py;
    logic        vsync;
    logic        scroll_en;
    logic        scroll_dir;
    logic [1:0]  speed;
    logic        cycle_en;
    logic [1:0]  r;
    logic [1:0]  g;
    logic [1:0]  b;
    logic        valid;
    logic [5:0]  rgb;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign rgb = {r, g, b};

    bg_scroll_layers #(
        .DWELL_FRAMES (2),
        .TRANS_FRAMES (1)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .bg_en_i        (bg_en),
        .video_active_i (video_active),
        .pix_x_i        (px),
        .pix_y_i        (py),
        .vsync_i        (vsync),
        .scroll_en_i    (scroll_en),
        .scroll_dir_i   (scroll_dir),
        .speed_i        (speed),
        .cycle_en_i     (cycle_en),
        .r_o            (r),
        .g_o            (g),
        .b_o            (b),
        .pix_valid_o    (valid)
    );

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called just after a falling edge; returns just after one.
    task automatic tick();
        vsync = 1'b1;
        @(negedge clk);
        vsync = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic pix(input int x, input int y, input logic [5:0] exp,
                       input string tag);
        px = 11'(x);
        py = 11'(y);
        @(negedge clk);
        @(negedge clk);
        chk(tag, 16'(rgb), 16'(exp));
    endtask

    initial begin
        rst          = 1'b1;
        bg_en        = 1'b1;
        video_active = 1'b1;
        px           = '0;
        py           = '0;
        vsync        = 1'b0;
        scroll_en    = 1'b0;
        scroll_dir   = 1'b0;
        speed        = 2'd0;
        cycle_en     = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rgb", 16'(rgb), 16'h0);
        chk("rst_valid", 16'(valid), 16'h0);
        rst = 1'b0;

        pix(96, 180, 6'b111111, "cloud0_day");
        chk("valid_on", 16'(valid), 16'h1);
        pix(63, 180, 6'b101011, "left_of_cloud0");
        pix(0, 703, 6'b101011, "sky_above_gnd");
        px = 11'd0;
        py = 11'd704;
        @(negedge clk);
        chk("lat_1clk", 16'(rgb), 16'b101011);
        @(negedge clk);
        chk("lat_2clk_brick", 16'(rgb), 16'b110100);
        pix(28, 704, 6'b000000, "gnd_mortar");
        pix(864, 128, 6'b111100, "sun_day");

        // Parallax: 8 ticks, step 1, scene moving left
        scroll_en = 1'b1;
        repeat (8) tick();
        chk("gnd_8", 16'(dut.gnd_pos), 16'd8);
        pix(92, 180, 6'b111111, "cloud0_at60");
        pix(59, 180, 6'b101011, "cloud0_left");
        pix(318, 228, 6'b111111, "cloud1_at318");
        pix(317, 228, 6'b101011, "cloud1_left");
        pix(575, 276, 6'b111111, "cloud2_at575");
        pix(574, 276, 6'b101011, "cloud2_left");

        // Ground wrap in both directions
        scroll_dir = 1'b1;
        speed      = 2'd3;
        tick();
        chk("gnd_dn8", 16'(dut.gnd_pos), 16'd0);
        speed = 2'd2;
        tick();
        chk("gnd_underflow", 16'(dut.gnd_pos), 16'd1020);
        scroll_dir = 1'b0;
        speed      = 2'd3;
        tick();
        chk("gnd_overflow", 16'(dut.gnd_pos), 16'd4);
        scroll_dir = 1'b1;
        tick();
        chk("gnd_back_1020", 16'(dut.gnd_pos), 16'd1020);
        pix(0, 704, 6'b000000, "gnd1020_col7");
        pix(4, 704, 6'b110100, "gnd1020_wrap_col0");

        // Stretched vsync gives one tick only
        scroll_dir = 1'b0;
        speed      = 2'd0;
        vsync      = 1'b1;
        repeat (100) @(negedge clk);
        vsync = 1'b0;
        repeat (2) @(negedge clk);
        chk("long_vsync", 16'(dut.gnd_pos), 16'd1021);

        // Disabled ticks are dropped, not deferred
        bg_en = 1'b0;
        tick();
        chk("bg_off_tick", 16'(dut.gnd_pos), 16'd1021);
        pix(4, 704, 6'b000000, "bg_off_black");
        vsync = 1'b1;
        repeat (2) @(negedge clk);
        bg_en = 1'b1;
        repeat (2) @(negedge clk);
        vsync = 1'b0;
        repeat (2) @(negedge clk);
        chk("no_deferred", 16'(dut.gnd_pos), 16'd1021);
        chk("sky_held_day", 16'(dut.state_q), 16'(DAY));

        // Reset for one clock in the middle of a line
        pix(864, 128, 6'b111100, "pre_rst_sun");
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_rgb", 16'(rgb), 16'h0);
        chk("mid_rst_valid", 16'(valid), 16'h0);
        chk("mid_rst_gnd", 16'(dut.gnd_pos), 16'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rel_1clk", 16'(rgb), 16'h0);
        @(negedge clk);
        chk("rel_2clk", 16'(rgb), 16'b111100);

        // Sky cycle: DWELL 2, TRANS 1
        scroll_en = 1'b0;
        repeat (2) tick();
        chk("cyc_off_hold", 16'(dut.state_q), 16'(DAY));
        cycle_en = 1'b1;
        tick();
        chk("sky_t1", 16'(dut.state_q), 16'(DAY));
        tick();
        chk("sky_t2", 16'(dut.state_q), 16'(DUSK));
        pix(864, 128, 6'b111100, "sun_dusk");
        pix(0, 703, 6'b110101, "sky_dusk");
        tick();
        chk("sky_t3", 16'(dut.state_q), 16'(NIGHT));
        pix(864, 128, 6'b101010, "moon_night");
        pix(0, 703, 6'b000001, "sky_night");
        pix(96, 180, 6'b010101, "cloud_night");
        cycle_en = 1'b0;
        repeat (3) tick();
        chk("night_hold", 16'(dut.state_q), 16'(NIGHT));
        cycle_en = 1'b1;
        tick();
        chk("sky_t4", 16'(dut.state_q), 16'(NIGHT));
        tick();
        chk("sky_t5", 16'(dut.state_q), 16'(DAWN));
        pix(0, 703, 6'b100110, "sky_dawn");
        pix(864, 128, 6'b111100, "sun_dawn");
        tick();
        chk("sky_t6", 16'(dut.state_q), 16'(DAY));
        chk("gnd_still", 16'(dut.gnd_pos), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
